// File: rtl/char_rng_stream_if.sv
// char_rng_stream_if
// Character beat stream from the random character source to the text-RAM writer.
//   c_valid : producer -> consumer, c_out holds a valid beat
//   c_ready : consumer -> producer, beat accepted when both are high
//   c_out   : LANES characters, lane i at [i*CHAR_WIDTH +: CHAR_WIDTH]
interface char_rng_stream_if #(
    parameter int LANES      = 4,
    parameter int CHAR_WIDTH = 8
);
    logic                        c_valid;
    logic                        c_ready;
    logic [LANES*CHAR_WIDTH-1:0] c_out;

    modport master (output c_valid, output c_out, input  c_ready);
    modport slave  (input  c_valid, input  c_out, output c_ready);
endinterface

// File: rtl/char_rng_stream.sv
// char_rng_stream
// Multi-lane pseudo-random character source. Each lane owns a 32-bit LCG;
// every generated beat maps the current lane states into [0, NUM_OF_CHARS)
// and then steps all lanes. Output uses a valid/ready handshake.
//
// Ports:
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   enable     : permit generation of new beats
//   seed_valid : load seed into all lanes, discard pending beat, clear beat_count
//   seed       : seed value (lane i gets seed ^ (i * 0x9E3779B9))
//   c_if       : beat stream (master side): c_valid, c_ready, c_out
//   beat_count : number of accepted beats since reset / last seed load
//
// Build option:
//   CHARGEN_TEMPER_EN : when defined, the character map uses the tempered
//                       value s ^ (s >> 15) instead of the raw state.
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | no beat pending, c_valid = 0
// S_FULL | beat held on c_out, c_valid = 1 until accepted
module char_rng_stream #(
    parameter int          CHAR_WIDTH   = 8,
    parameter int          NUM_OF_CHARS = 96,
    parameter int          LANES        = 4,
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              seed_valid,
    input  logic [31:0]       seed,
    char_rng_stream_if.master c_if,
    output logic [31:0]       beat_count
);

    if (NUM_OF_CHARS < 1 || NUM_OF_CHARS > (1 << CHAR_WIDTH)) begin : g_bad_nchars
        $error("char_rng_stream: NUM_OF_CHARS must be in 1..2^CHAR_WIDTH");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("char_rng_stream: LANES must be in 1..16");
    end

    localparam logic [31:0]         LCG_MUL     = 32'd1664525;
    localparam logic [31:0]         LCG_INC     = 32'd1013904223;
    localparam logic [31:0]         SEED_SPREAD = 32'h9E37_79B9;
    localparam logic [CHAR_WIDTH:0] NCHARS      = NUM_OF_CHARS[CHAR_WIDTH:0];

    // Scales the top 16 bits into [0, NUM_OF_CHARS). The product's top bit
    // is always zero because NUM_OF_CHARS <= 2^CHAR_WIDTH.
    function automatic logic [CHAR_WIDTH-1:0] map_char(input logic [31:0] s);
        logic [31:0]            t;
        logic [16+CHAR_WIDTH:0] prod;
`ifdef CHARGEN_TEMPER_EN
        t = s ^ (s >> 15);
`else
        t = s;
`endif
        prod = {{(CHAR_WIDTH+1){1'b0}}, t[31:16]} * {16'd0, NCHARS};
        return prod[16 +: CHAR_WIDTH];
    endfunction

    typedef enum logic {S_IDLE, S_FULL} state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        c_valid;
    logic                        hs;
    logic                        adv;
    logic [LANES*CHAR_WIDTH-1:0] char_vec;
    logic [LANES*CHAR_WIDTH-1:0] c_out_q;

    assign c_valid     = (state_q == S_FULL);
    assign c_if.c_valid = c_valid;
    assign c_if.c_out   = c_out_q;
    assign hs          = c_valid && c_if.c_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        adv     = 1'b0;
        state_d = state_q;
        if (seed_valid) begin
            // Seed load discards any pending beat, even one accepted this cycle.
            state_d = S_IDLE;
        end else if (enable && (!c_valid || c_if.c_ready)) begin
            adv     = 1'b1;
            state_d = S_FULL;
        end else if (hs) begin
            state_d = S_IDLE;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] s_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s_q <= SEED_DEFAULT + 32'(g);
            end else if (seed_valid) begin
                s_q <= seed ^ (32'(g) * SEED_SPREAD);
            end else if (adv) begin
                s_q <= s_q * LCG_MUL + LCG_INC;
            end
        end

        assign char_vec[g*CHAR_WIDTH +: CHAR_WIDTH] = map_char(s_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_out_q <= '0;
        end else if (adv) begin
            c_out_q <= char_vec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_count <= '0;
        end else if (seed_valid) begin
            beat_count <= '0;
        end else if (hs) begin
            beat_count <= beat_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_char_rng_stream.sv
// tb_char_rng_stream
// Bench for char_rng_stream: a transaction-level model (pending beat index
// per seed epoch, accepted-beat count) checked every negedge, directed
// literal expectations, async reset check and a range sweep on three
// NUM_OF_CHARS variants.
module tb_char_rng_stream;

    localparam int CW    = 8;
    localparam int N     = 96;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = 32'd0;
    logic [31:0] beat_count;
    logic        sweep_en = 1'b0;
    logic [31:0] bc_n1, bc_n95, bc_n256;

    int n_checks = 0;
    int n_fail   = 0;

    char_rng_stream_if #(.LANES(LANES), .CHAR_WIDTH(CW)) sif ();
    char_rng_stream_if #(.LANES(LANES), .CHAR_WIDTH(CW)) sif_n1 ();
    char_rng_stream_if #(.LANES(LANES), .CHAR_WIDTH(CW)) sif_n95 ();
    char_rng_stream_if #(.LANES(LANES), .CHAR_WIDTH(CW)) sif_n256 ();

    always #5 clk = ~clk;

    char_rng_stream #(.CHAR_WIDTH(CW), .NUM_OF_CHARS(N), .LANES(LANES)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seed_valid(seed_valid),
        .seed(seed), .c_if(sif.master), .beat_count(beat_count));

    char_rng_stream #(.CHAR_WIDTH(CW), .NUM_OF_CHARS(1), .LANES(LANES)) dut_n1 (
        .clk(clk), .reset_n(reset_n), .enable(sweep_en), .seed_valid(1'b0),
        .seed(32'd0), .c_if(sif_n1.master), .beat_count(bc_n1));

    char_rng_stream #(.CHAR_WIDTH(CW), .NUM_OF_CHARS(95), .LANES(LANES)) dut_n95 (
        .clk(clk), .reset_n(reset_n), .enable(sweep_en), .seed_valid(1'b0),
        .seed(32'd0), .c_if(sif_n95.master), .beat_count(bc_n95));

    char_rng_stream #(.CHAR_WIDTH(CW), .NUM_OF_CHARS(256), .LANES(LANES)) dut_n256 (
        .clk(clk), .reset_n(reset_n), .enable(sweep_en), .seed_valid(1'b0),
        .seed(32'd0), .c_if(sif_n256.master), .beat_count(bc_n256));

    assign sif_n1.c_ready   = 1'b1;
    assign sif_n95.c_ready  = 1'b1;
    assign sif_n256.c_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        longint unsigned v;
        v = {32'd0, s};
        v = (v * 64'd1664525 + 64'd1013904223) % 64'h1_0000_0000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] seeded_lane(input logic [31:0] sd, input int i);
        longint unsigned k;
        k = (longint'(i) * 64'h9E37_79B9) % 64'h1_0000_0000;
        return sd ^ k[31:0];
    endfunction

    function automatic logic [CW-1:0] ref_char(input logic [31:0] s, input int nchars);
        longint unsigned v, hi;
        v = {32'd0, s};
`ifdef CHARGEN_TEMPER_EN
        v = v ^ (v / 64'd32768);
`endif
        hi = v / 64'd65536;
        hi = (hi * longint'(nchars)) / 64'd65536;
        return hi[CW-1:0];
    endfunction

    // m_state: lane states that produce the beat that is (or next will be) pending.
    logic [31:0] m_state [LANES];
    bit          m_valid;
    int unsigned m_count;

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) m_state[l] = 32'h0000_0001 + 32'(l);
        m_valid = 1'b0;
        m_count = 0;
    endtask

    function automatic logic [LANES*CW-1:0] model_beat();
        logic [LANES*CW-1:0] b;
        for (int l = 0; l < LANES; l++) b[l*CW +: CW] = ref_char(m_state[l], N);
        return b;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_valid", {63'd0, sif.c_valid}, 64'd0);
                check("rst_cout", {32'd0, sif.c_out}, 64'd0);
                check("rst_count", {32'd0, beat_count}, 64'd0);
                model_reset();
            end else begin
                check("valid", {63'd0, sif.c_valid}, {63'd0, m_valid});
                if (m_valid) check("c_out", {32'd0, sif.c_out}, {32'd0, model_beat()});
                check("beat_count", {32'd0, beat_count}, {32'd0, m_count});
                // advance model to what the coming edge must produce
                if (seed_valid) begin
                    for (int l = 0; l < LANES; l++) m_state[l] = seeded_lane(seed, l);
                    m_valid = 1'b0;
                    m_count = 0;
                end else begin
                    if (m_valid && sif.c_ready) begin
                        m_count++;
                        for (int l = 0; l < LANES; l++) m_state[l] = lcg_next(m_state[l]);
                    end
                    m_valid = enable ? 1'b1 : (m_valid && !sif.c_ready);
                end
            end
        end
    end

    // ---------------- range sweep monitor ----------------
    bit seen1 [256];
    bit seen95 [256];
    bit seen256 [256];
    int bad1 = 0, bad95 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (sweep_en && reset_n) begin
                for (int l = 0; l < LANES; l++) begin
                    if (sif_n1.c_valid) begin
                        seen1[sif_n1.c_out[l*CW +: CW]] = 1'b1;
                        if (sif_n1.c_out[l*CW +: CW] >= 8'd1) bad1++;
                    end
                    if (sif_n95.c_valid) begin
                        seen95[sif_n95.c_out[l*CW +: CW]] = 1'b1;
                        if (sif_n95.c_out[l*CW +: CW] >= 8'd95) bad95++;
                    end
                    if (sif_n256.c_valid) seen256[sif_n256.c_out[l*CW +: CW]] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pat_en;
        logic [15:0] pat_rdy;
        int cnt1, cnt95, cnt256;
        pat_en  = 16'b1011_1101_0110_1111;
        pat_rdy = 16'b1100_1011_1010_0111;
        sif.c_ready = 1'b0;

        repeat (3) tick();
        reset_n = 1'b1;

        // default seed sequence
        enable = 1'b1;
        sif.c_ready = 1'b1;
        tick();
        check("def_lane0_b1", {56'd0, sif.c_out[7:0]}, 64'd0);
        check("def_count_b1", {32'd0, beat_count}, 64'd0);
        tick();
        check("def_lane0_b2", {56'd0, sif.c_out[7:0]}, 64'd22);
        check("def_count_b2", {32'd0, beat_count}, 64'd1);
        tick();
        check("def_count_b3", {32'd0, beat_count}, 64'd2);
        repeat (3) tick();

        // seed load with seed = 0
        seed_valid = 1'b1;
        seed = 32'd0;
        tick();
        check("seed_valid_clr", {63'd0, sif.c_valid}, 64'd0);
        check("seed_count_clr", {32'd0, beat_count}, 64'd0);
        seed_valid = 1'b0;
        tick();
        check("seed0_lane0_b1", {56'd0, sif.c_out[7:0]}, 64'd0);
        check("seed0_lane1_b1", {56'd0, sif.c_out[15:8]}, 64'd59);
        tick();
        check("seed0_lane0_b2", {56'd0, sif.c_out[7:0]}, 64'd22);
        check("seed0_count", {32'd0, beat_count}, 64'd1);

        // backpressure: five stalled cycles
        sif.c_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {63'd0, sif.c_valid}, 64'd1);
            check("stall_count", {32'd0, beat_count}, 64'd1);
            check("stall_lane0", {56'd0, sif.c_out[7:0]}, 64'd22);
        end
        sif.c_ready = 1'b1;
        repeat (3) tick();

        // seed while a beat is stalled
        sif.c_ready = 1'b0;
        tick();
        seed_valid = 1'b1;
        seed = 32'h1234_5678;
        tick();
        check("seed_stall_valid", {63'd0, sif.c_valid}, 64'd0);
        check("seed_stall_count", {32'd0, beat_count}, 64'd0);
        seed_valid = 1'b0;
        sif.c_ready = 1'b1;
        repeat (4) tick();

        // enable low with a pending beat
        enable = 1'b0;
        sif.c_ready = 1'b0;
        tick();
        tick();
        check("hold_pending", {63'd0, sif.c_valid}, 64'd1);
        sif.c_ready = 1'b1;
        tick();
        check("drop_after_accept", {63'd0, sif.c_valid}, 64'd0);
        tick();

        // directed pattern mix, with seeds sprinkled in
        for (int i = 0; i < 160; i++) begin
            enable      = pat_en[i % 16];
            sif.c_ready = pat_rdy[(i * 3) % 16];
            seed_valid  = (i == 40 || i == 41 || i == 97 || i == 130);
            seed        = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        seed_valid = 1'b0;

        // async reset mid-handshake
        enable = 1'b1;
        sif.c_ready = 1'b1;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, sif.c_valid}, 64'd0);
        check("async_rst_cout", {32'd0, sif.c_out}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_lane0_b1", {56'd0, sif.c_out[7:0]}, 64'd0);
        tick();
        check("post_rst_lane0_b2", {56'd0, sif.c_out[7:0]}, 64'd22);

        // range sweep on the NUM_OF_CHARS variants
        sweep_en = 1'b1;
        repeat (10000) tick();
        sweep_en = 1'b0;
        tick();
        cnt1 = 0; cnt95 = 0; cnt256 = 0;
        for (int v = 0; v < 256; v++) begin
            cnt1   += int'(seen1[v]);
            cnt95  += int'(seen95[v]);
            cnt256 += int'(seen256[v]);
        end
        check("sweep_n1_range", 64'(bad1), 64'd0);
        check("sweep_n95_range", 64'(bad95), 64'd0);
        check("sweep_n1_coverage", 64'(cnt1), 64'd1);
        check("sweep_n95_coverage", 64'(cnt95), 64'd95);
        check("sweep_n256_coverage", 64'(cnt256), 64'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_rng_stream.md
Name: char_rng_stream

Overview:
- Multi-lane pseudo-random character source for the XGA text path.
- Produces LANES characters per beat, each uniformly mapped into [0, NUM_OF_CHARS).
- Each lane runs its own 32-bit LCG; generators are seedable at run time.
- Output uses a valid/ready handshake so the text-RAM writer can apply backpressure.

Parameters:
CHAR_WIDTH, 8, bits per character code
NUM_OF_CHARS, 96, size of character set; must satisfy 1 <= NUM_OF_CHARS <= 2^CHAR_WIDTH (elaboration error otherwise)
LANES, 4, characters produced per beat (1..16)
SEED_DEFAULT, 32'h0000_0001, lane-0 state after reset

Ports:
clk  in  1  system clock
reset_n  in  1  reset
enable  in  1  permit generation of new beats
seed_valid  in  1  load seed into all lanes this cycle
seed  in  32  seed value
c_valid  out  1  c_out holds a valid beat
c_ready  in  1  consumer accepts beat
c_out  out  LANES*CHAR_WIDTH  lane i occupies bits [i*CHAR_WIDTH +: CHAR_WIDTH]
beat_count  out  32  number of accepted beats

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - lane i state = SEED_DEFAULT + i (mod 2^32)
  - c_valid = 0, c_out = 0, beat_count = 0
- LCG step per lane: s' = (s * 1664525 + 1013904223) mod 2^32. Full 32-bit wrap, no masking.
- Character map per lane:
  - char_i = (s_i[31:16] * NUM_OF_CHARS) >> 16
  - 16 x CHAR_WIDTH+1 bit product; result < NUM_OF_CHARS always; zero-extended to CHAR_WIDTH.
- Advance condition: adv = enable && !seed_valid && (!c_valid || c_ready).
  - On adv: c_out <= map(current states); all states step; c_valid <= 1.
- Latency: first beat valid 1 cycle after enable is sampled high.
- Hold:
  - c_valid && !c_ready: c_out and states frozen.
  - enable low: no new beat is produced; any pending beat stays valid until accepted, then c_valid <= 0.
- Drop: c_valid && c_ready && !adv means c_valid <= 0 next cycle.
- Seed load:
  - seed_valid: lane i state <= seed ^ (i * 32'h9E37_79B9) (mod 2^32).
  - Also sets c_valid <= 0 (pending beat discarded) and beat_count <= 0.
  - seed_valid has priority over adv.
  - If c_valid && c_ready in the same cycle, that transfer still counts as completed at the consumer, but beat_count still clears.
- beat_count: increments on c_valid && c_ready; wraps 32'hFFFF_FFFF -> 0.
- Reset asserted mid-stream: everything returns to reset values immediately; no partial beat survives.
- States:
  - IDLE (c_valid=0) -> FULL on adv.
  - FULL -> FULL on handshake plus adv.
  - FULL -> IDLE on handshake without adv, or on seed_valid.

Optional Feature:
- Macro CHARGEN_TEMPER_EN.
- Defined: the map input is t = s ^ (s >> 15), using t[31:16] in place of s[31:16]. Adds no latency; state sequence is unchanged.
- Undefined: raw s[31:16] is used, and the Test Plan values below apply.

Test Plan:
- Reset, enable=1, c_ready=1, defaults -> lane0 beat 1 = 0, beat 2 = 22 (state 0x3C88596C); beat_count 1 then 2.
- Reset, then seed_valid with seed=0, then enable=1, c_ready=1 -> lane0 beat 1 = 0, beat 2 = 22 (state 0x3C6EF35F); beat_count restarts from 0.
- Backpressure: c_ready=0 for 5 cycles after first valid -> c_out stable, c_valid=1, beat_count unchanged; release -> next beat equals the unblocked-sequence value.
- seed_valid while c_valid=1 and c_ready=0 -> c_valid=0 next cycle, beat_count=0, next beat taken from seeded state.
- Range sweep: NUM_OF_CHARS=1, 95, 256 at CHAR_WIDTH=8 over 10k beats -> every lane value < NUM_OF_CHARS, and all NUM_OF_CHARS values observed.
- reset_n pulsed low asynchronously mid-handshake -> c_valid drops without waiting for a clock edge; lane0 restarts at the SEED_DEFAULT sequence.
